sysid_checker: RTL
==================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- EXPECTED_ID, 0, expected system ID word (address 0).
- EXPECTED_TS, 1490048502, expected build timestamp word (address 1).
- READ_LATENCY, 1, cycles from accepted read to valid readdata; legal values 0..3.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest cycles before abort; legal range 1..65535.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock; all logic on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a check sequence.
- avm_address, out, 1, sysid word select: 0 = ID, 1 = timestamp.
- avm_read, out, 1, Avalon-MM read strobe.
- avm_readdata, in, 32, sysid read data.
- avm_waitrequest, in, 1, slave stall; tie to 0 for a zero-wait slave.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse when the sequence ends.
- id_ok, out, 1, captured ID equals EXPECTED_ID; valid while done and afterwards.
- ts_ok, out, 1, captured timestamp equals EXPECTED_TS; valid while done and afterwards.
- timeout, out, 1, the sequence aborted on a waitrequest timeout.
- id_value, out, 32, last captured ID word.
- ts_value, out, 32, last captured timestamp word.

Function
REQ-003 The FSM SHALL have the states IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS and FIN.
REQ-004 In IDLE, start=1 SHALL move the FSM to RD_ID and clear id_ok, ts_ok, timeout, id_value and ts_value in that same edge.
REQ-005 In RD_ID the block SHALL drive avm_read=1 and avm_address=0, and SHALL hold both stable while avm_waitrequest=1.
REQ-006 A read SHALL be accepted on the edge where avm_read=1 and avm_waitrequest=0.
REQ-007 If READ_LATENCY=0, the block SHALL capture avm_readdata on the accept edge; otherwise it SHALL wait in LAT_ID for READ_LATENCY cycles with avm_read=0 and capture on the final one.
REQ-008 After the ID capture, the block SHALL perform RD_TS/LAT_TS with avm_address=1 in the same way and then enter FIN.
REQ-009 Minimum sequence length SHALL be 2*(1+READ_LATENCY)+1 cycles from start to the done pulse.
REQ-010 A waitrequest counter SHALL count consecutive stalled cycles in RD_ID or RD_TS and SHALL reset when a read is accepted.
REQ-011 When the counter reaches TIMEOUT_CYCLES, the block SHALL drop avm_read, set timeout=1 and enter FIN; any word not yet captured SHALL leave its _ok flag at 0.
REQ-012 In FIN the block SHALL pulse done for one cycle, latch id_ok and ts_ok from full 32-bit equality compares, deassert busy and return to IDLE.
REQ-013 start while busy SHALL be ignored; start in the same cycle as done SHALL be ignored.
REQ-014 avm_read SHALL never be asserted outside RD_ID and RD_TS.

Reset
REQ-015 While reset_n=0, all outputs and the counters SHALL be 0 and the state SHALL be IDLE, asynchronously, including mid-transaction.
REQ-016 After reset_n deasserts, the block SHALL stay idle and SHALL NOT issue a read until start=1.

Structure
REQ-017 State encodings, address constants (ID=0, TS=1) and the counter width (16) SHALL live in a shared package or header.
REQ-018 A single sub-module, sysid_wait_timer, SHALL implement the shared latency and timeout counter; all other logic SHALL be flat.

Verification
REQ-019 Zero-wait slave returning 0 and 1490048502 with READ_LATENCY=1: start -> done on cycle 5, id_ok=1, ts_ok=1, timeout=0.
REQ-020 Slave returning 1490048501 for the timestamp -> id_ok=1, ts_ok=0, ts_value=1490048501.
REQ-021 waitrequest held high for 3 cycles on each read -> avm_address and avm_read stable throughout, done on cycle 11, both _ok=1.
REQ-022 TIMEOUT_CYCLES=4 with waitrequest stuck high -> avm_read high for exactly 4 cycles, then timeout=1, done pulse, id_ok=0, ts_ok=0.
REQ-023 reset_n pulsed low during LAT_TS -> all outputs 0 immediately; a subsequent start completes normally.
REQ-024 start pulsed during busy and coincident with done -> no second sequence; avm_read counted exactly 2 accepts.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// Shared state encoding, sysid word addresses and counter width for the sysid checker.
package sysid_checker_pkg;

  localparam int CNT_W = 16;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    FIN    = 3'd5
  } state_t;

endpackage

// File: rtl/sysid_wait_timer.sv
// Shared cycle counter: counts read latency cycles or consecutive stall cycles.
// expire flags the increment that brings the count up to limit.
module sysid_wait_timer
  import sysid_checker_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_nxt;

  assign count_nxt = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign expire    = inc && (count_nxt == {1'b0, limit});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_nxt[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them to expected values.
// Sequence takes 2*(1+READ_LATENCY)+1 cycles plus stalls; a stuck waitrequest aborts after TIMEOUT_CYCLES.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1490048502,
  parameter int          READ_LATENCY   = 1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [CNT_W-1:0] LAT_LIM = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               NO_LAT  = (READ_LATENCY == 0);

  state_t           state, state_nxt;
  logic             rd_phase, lat_phase, accept, expire;
  logic             cap_id, cap_ts, tmr_clr, tmr_inc;
  logic [CNT_W-1:0] tmr_limit;

  assign rd_phase    = (state == RD_ID) || (state == RD_TS);
  assign lat_phase   = (state == LAT_ID) || (state == LAT_TS);
  assign accept      = rd_phase && !avm_waitrequest;
  assign avm_read    = rd_phase;
  assign avm_address = (state == RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy        = (state != IDLE) && (state != FIN);
  assign done        = (state == FIN);

  // One timer serves both phases: cleared on every state change, so it
  // counts either stalled cycles in a read state or cycles spent in latency.
  assign tmr_clr   = (state_nxt != state);
  assign tmr_inc   = (rd_phase && avm_waitrequest) || lat_phase;
  assign tmr_limit = lat_phase ? LAT_LIM : TO_LIM;

  assign cap_id = NO_LAT ? ((state == RD_ID) && accept) : ((state == LAT_ID) && expire);
  assign cap_ts = NO_LAT ? ((state == RD_TS) && accept) : ((state == LAT_TS) && expire);

  sysid_wait_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .limit   (tmr_limit),
    .expire  (expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_ID;
      end
      RD_ID: begin
        if (accept)      state_nxt = NO_LAT ? RD_TS : LAT_ID;
        else if (expire) state_nxt = FIN;
      end
      LAT_ID: begin
        if (expire) state_nxt = RD_TS;
      end
      RD_TS: begin
        if (accept)      state_nxt = NO_LAT ? FIN : LAT_TS;
        else if (expire) state_nxt = FIN;
      end
      LAT_TS: begin
        if (expire) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
      end
      if (cap_id) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TS);
      end
      // expire in a read state can only come from a stall, never an accept
      if (rd_phase && expire) timeout <= 1'b1;
    end
  end

endmodule
